// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, memory and status signals of the shared memory port
// Purpose: bundles the fetch (i_*), load/store (d_*) and memory (mem_*) handshakes.
// Modports: slave = arbiter view, master = core/memory/testbench view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              bus_err;
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_ack, i_rdata, d_ack, d_rdata, mem_read, mem_write, mem_addr, mem_wdata,
           bus_err, busy
  );

  modport master (
    output i_req, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_read, mem_write, mem_addr, mem_wdata,
           bus_err, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory/IO port between fetch and load/store requesters
// Purpose: one access in flight; IDLE -> GRANT_I|GRANT_D -> RESP -> IDLE, with bus timeout.
// Ports: clk (rising edge), nrst (asynchronous, active-low),
//        bus (mem_port_arbiter_if.slave): i_* fetch, d_* load/store, mem_* memory, bus_err, busy.
// Option: ARB_ROUND_ROBIN_EN alternates simultaneous I/D requests; undefined = fixed D over I.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              nrst,
  mem_port_arbiter_if.slave bus
);

  localparam int                CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit                TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_GRANT_I, S_GRANT_D, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_owner_d;
  logic              r_op_write;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_any_d;
  logic w_grant_d;
  logic w_grant_i;
  logic w_in_grant;
  logic w_timeout;

  assign w_any_d    = bus.d_read | bus.d_write;
  assign w_in_grant = (r_state == S_GRANT_I) || (r_state == S_GRANT_D);
  // A mem_ack in the last allowed cycle still completes normally.
  assign w_timeout  = TO_EN && w_in_grant && (r_cnt == CNT_LAST) && !bus.mem_ack;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;

  // On a tie, the requester that did not win last time goes first.
  assign w_grant_d = w_any_d & (~bus.i_req | ~r_last_d);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_last_d <= 1'b1;
    end else if ((r_state == S_IDLE) && (w_any_d || bus.i_req)) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  assign w_grant_d = w_any_d;
`endif

  assign w_grant_i = bus.i_req & ~w_grant_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          w_next = S_GRANT_D;
        end else if (w_grant_i) begin
          w_next = S_GRANT_I;
        end
      end
      S_GRANT_I, S_GRANT_D: begin
        if (bus.mem_ack || w_timeout) begin
          w_next = S_RESP;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (r_state != S_IDLE);
    bus.mem_read  = w_in_grant & ~r_op_write;
    bus.mem_write = w_in_grant & r_op_write;
    bus.mem_addr  = r_addr;
    bus.mem_wdata = r_wdata;
    bus.i_ack     = (r_state == S_RESP) & ~r_owner_d;
    bus.d_ack     = (r_state == S_RESP) & r_owner_d;
    bus.bus_err   = (r_state == S_RESP) & r_err;
    bus.i_rdata   = r_i_rdata;
    bus.d_rdata   = r_d_rdata;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_owner_d  <= 1'b0;
      r_op_write <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_grant_d) begin
        r_owner_d  <= 1'b1;
        r_op_write <= bus.d_write;
        r_addr     <= bus.d_addr;
        r_wdata    <= bus.d_wdata;
        r_cnt      <= '0;
        r_err      <= 1'b0;
      end else if (w_grant_i) begin
        r_owner_d  <= 1'b0;
        r_op_write <= 1'b0;
        r_addr     <= bus.i_addr;
        r_wdata    <= '0;
        r_cnt      <= '0;
        r_err      <= 1'b0;
      end
    end else if (w_in_grant) begin
      if (r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (bus.mem_ack) begin
        if (!r_op_write) begin
          if (r_owner_d) begin
            r_d_rdata <= bus.mem_rdata;
          end else begin
            r_i_rdata <= bus.mem_rdata;
          end
        end
      end else if (w_timeout) begin
        // Aborted access: owner sees zero data alongside bus_err.
        r_err <= 1'b1;
        if (r_owner_d) begin
          r_d_rdata <= '0;
        end else begin
          r_i_rdata <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int T = 4;

  logic clk = 1'b0;
  logic nrst;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: registered read data per requester and the last winner.
  logic [31:0] m_i_rdata;
  logic [31:0] m_d_rdata;
  bit          m_last_d;

  typedef struct {
    bit          ir;
    int          dop;    // 0 none, 1 read, 2 write, 3 read+write
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] dw;
    logic [31:0] ri;
    logic [31:0] rd;
    int          lat_i;  // GRANT cycle index carrying mem_ack
    int          lat_d;
    bit          exp_first_d;
    int          exp_lat;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_i_ack"}, bus.i_ack, 0);
    chk({tag, "_d_ack"}, bus.d_ack, 0);
    chk({tag, "_bus_err"}, bus.bus_err, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_mem_read"}, bus.mem_read, 0);
    chk({tag, "_mem_write"}, bus.mem_write, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_i_rdata"}, bus.i_rdata, 0);
    chk({tag, "_d_rdata"}, bus.d_rdata, 0);
  endtask

  // Serves every requester raised at once, in the order the arbitration rules dictate.
  task automatic scenario(input bit ir, input int dop, input logic [31:0] ia, da, dw, ri, rd,
                          input int lat_i, lat_d, input bit spur, input bit drop,
                          output bit first_d, output int first_lat, output bit first_err);
    bit          order_d [2];
    int          n;
    bit          isd;
    bit          wr;
    bit          err;
    int          lat;
    int          gc;
    logic [31:0] addr;
    logic [31:0] rdv;
    n         = 0;
    first_d   = 0;
    first_lat = 0;
    first_err = 0;
    if (ir && dop != 0) begin
`ifdef ARB_ROUND_ROBIN_EN
      order_d[0] = !m_last_d;
`else
      order_d[0] = 1'b1;
`endif
      order_d[1] = !order_d[0];
      n = 2;
    end else if (dop != 0) begin
      order_d[0] = 1'b1;
      n = 1;
    end else if (ir) begin
      order_d[0] = 1'b0;
      n = 1;
    end
    bus.i_req   = ir;
    bus.i_addr  = ia;
    bus.d_read  = (dop == 1) || (dop == 3);
    bus.d_write = (dop >= 2);
    bus.d_addr  = da;
    bus.d_wdata = dw;
    if (n == 0) begin
      step();
      chk("none_busy", bus.busy, 0);
    end
    for (int k = 0; k < n; k++) begin
      isd      = order_d[k];
      wr       = isd && (dop >= 2);
      addr     = isd ? da : ia;
      lat      = isd ? lat_d : lat_i;
      rdv      = isd ? rd : ri;
      err      = (T != 0) && (lat >= T);
      gc       = err ? T : lat + 1;
      m_last_d = isd;
      step();
      for (int g = 0; g < gc; g++) begin
        chk("gnt_mem_read", bus.mem_read, !wr);
        chk("gnt_mem_write", bus.mem_write, wr);
        chk("gnt_mem_addr", bus.mem_addr, addr);
        if (wr) chk("gnt_mem_wdata", bus.mem_wdata, dw);
        chk("gnt_busy", bus.busy, 1);
        chk("gnt_acks", {bus.i_ack, bus.d_ack, bus.bus_err}, 0);
        bus.mem_ack   = (g == lat);
        bus.mem_rdata = (g == lat) ? rdv : $urandom;
        if (drop && g == 0) begin
          if (isd) begin
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
          end else begin
            bus.i_req = 1'b0;
          end
        end
        step();
      end
      bus.mem_ack = spur;
      if (err) begin
        if (isd) m_d_rdata = 0; else m_i_rdata = 0;
      end else if (!wr) begin
        if (isd) m_d_rdata = rdv; else m_i_rdata = rdv;
      end
      chk("resp_i_ack", bus.i_ack, !isd);
      chk("resp_d_ack", bus.d_ack, isd);
      chk("resp_bus_err", bus.bus_err, err);
      chk("resp_strobes", {bus.mem_read, bus.mem_write}, 0);
      chk("resp_i_rdata", bus.i_rdata, m_i_rdata);
      chk("resp_d_rdata", bus.d_rdata, m_d_rdata);
      if (k == 0) begin
        first_d   = isd;
        first_lat = gc + 1;
        first_err = err;
      end
      if (isd) begin
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
      end else begin
        bus.i_req = 1'b0;
      end
      step();
      chk("idle_busy", bus.busy, 0);
      chk("idle_acks", {bus.i_ack, bus.d_ack, bus.bus_err}, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs [7];
    bit          fd;
    int          fl;
    bit          fe;
    int          nacks;
    int          c0;
    int          c1;

    vecs[0] = '{1, 0, 32'h0000_0100, 0, 0, 32'hDEAD_BEEF, 0, 1, 0, 0, 3, 0};
    vecs[1] = '{0, 1, 0, 32'h0000_0500, 0, 0, 32'h3333_3333, 0, 3, 1, 5, 0};
    vecs[2] = '{0, 2, 0, 32'hFFFF_FFFF, 32'h0000_005A, 0, 0, 0, 0, 1, 2, 0};
    vecs[3] = '{1, 1, 32'h0000_0200, 32'h0000_0300, 0, 32'h1111_1111, 32'h2222_2222, 0, 0, 1, 2, 0};
    vecs[4] = '{0, 1, 0, 32'h0000_0400, 0, 0, 32'h4444_4444, 0, 9, 1, 5, 1};
    vecs[5] = '{1, 0, 32'h0000_0600, 0, 0, 32'h5555_5555, 0, 4, 0, 0, 5, 1};
    vecs[6] = '{0, 3, 0, 32'h0000_0700, 32'h0000_ABCD, 0, 32'h6666_6666, 0, 2, 1, 4, 0};

    bus.i_req = 0; bus.i_addr = 0; bus.d_read = 0; bus.d_write = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ack = 0;
    m_i_rdata = 0; m_d_rdata = 0; m_last_d = 1;
    nrst = 1'b0;
    #3;
    check_all_zero("reset");
    step();
    step();
    nrst = 1'b1;
    step();

    for (int v = 0; v < 7; v++) begin
      scenario(vecs[v].ir, vecs[v].dop, vecs[v].ia, vecs[v].da, vecs[v].dw, vecs[v].ri,
               vecs[v].rd, vecs[v].lat_i, vecs[v].lat_d, 0, 0, fd, fl, fe);
      chk($sformatf("vec%0d_latency", v), fl, vecs[v].exp_lat);
      chk($sformatf("vec%0d_err", v), fe, vecs[v].exp_err);
`ifndef ARB_ROUND_ROBIN_EN
      chk($sformatf("vec%0d_first_d", v), fd, vecs[v].exp_first_d);
`endif
    end

    for (int r = 0; r < 60; r++) begin
      scenario($urandom_range(0, 1), $urandom_range(0, 3), $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom_range(0, T + 2), $urandom_range(0, T + 2),
               $urandom_range(0, 1), $urandom_range(0, 1), fd, fl, fe);
    end
    bus.mem_ack = 0;
    step();

    // Back-to-back loads: request held through the ack, memory answers at once.
    bus.d_read    = 1'b1;
    bus.d_addr    = 32'h0000_0900;
    bus.mem_rdata = 32'hCAFE_F00D;
    nacks = 0;
    c0 = 0;
    c1 = 0;
    for (int c = 0; c < 14; c++) begin
      step();
      bus.mem_ack = bus.mem_read;
      if (bus.d_ack) begin
        if (nacks == 0) c0 = c; else c1 = c;
        nacks++;
        if (nacks == 2) bus.d_read = 1'b0;
      end
    end
    bus.mem_ack = 0;
    m_d_rdata = 32'hCAFE_F00D;
    m_last_d  = 1;
    chk("b2b_ack_count", nacks, 2);
    chk("b2b_ack_spacing", c1 - c0, 3);
    chk("b2b_d_rdata", bus.d_rdata, m_d_rdata);

    // Reset in the middle of a D grant.
    bus.d_read = 1'b1;
    bus.d_addr = 32'h0000_0800;
    step();
    step();
    chk("rst_pre_mem_read", bus.mem_read, 1);
    #2;
    nrst = 1'b0;
    #1;
    m_i_rdata = 0; m_d_rdata = 0; m_last_d = 1;
    check_all_zero("rst_mid");
    bus.d_read = 1'b0;
    step();
    nrst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rst_post_acks", {bus.i_ack, bus.d_ack, bus.bus_err, bus.busy}, 0);
    end

    // After reset, a tie goes to D (fixed) or to I (alternating, last winner reset to D).
    scenario(1, 1, 32'h0000_0A00, 32'h0000_0B00, 0, 32'h7777_7777, 32'h8888_8888,
             0, 0, 0, 0, fd, fl, fe);
`ifdef ARB_ROUND_ROBIN_EN
    chk("post_rst_tie_first_d", fd, 0);
`else
    chk("post_rst_tie_first_d", fd, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
